// File: rtl/adsr_envelope.sv
// -----------------------------------------------------------------------------
// adsr_envelope
//
// Per-voice ADSR envelope generator. Produces the 31-bit amplitude word used
// by the sine wave generator. A key gate starts and stops the envelope. The
// amplitude moves on a slow internal tick (TICK_DIV clocks per tick), so notes
// fade in and out instead of clicking.
//
// Parameters
//   CLOCK_FREQUENCY : system clock rate in Hz (documentation / sanity check)
//   TICK_DIV        : clocks per envelope tick, >= 2
//
// Ports
//   clk           in   system clock, all logic on posedge
//   reset         in   synchronous, active-high reset
//   gate          in   key held, synchronous to clk
//   peak_level    in   [30:0] attack target amplitude
//   sustain_level in   [30:0] sustain amplitude, clamped to peak_level
//   attack_step   in   [15:0] increment per tick in ATTACK
//   decay_step    in   [15:0] decrement per tick in DECAY
//   release_step  in   [15:0] decrement per tick in RELEASE
//   amplitude     out  [30:0] registered envelope value
//   env_state     out  [2:0]  IDLE=0 ATTACK=1 DECAY=2 SUSTAIN=3 RELEASE=4
//   active        out  high whenever env_state != IDLE
//   done          out  one-cycle pulse when RELEASE reaches 0
// -----------------------------------------------------------------------------
module adsr_envelope #(
    parameter int CLOCK_FREQUENCY = 50000000,
    parameter int TICK_DIV        = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [30:0] peak_level,
    input  logic [30:0] sustain_level,
    input  logic [15:0] attack_step,
    input  logic [15:0] decay_step,
    input  logic [15:0] release_step,
    output logic [30:0] amplitude,
    output logic [2:0]  env_state,
    output logic        active,
    output logic        done
);

    if (TICK_DIV < 2 || TICK_DIV > CLOCK_FREQUENCY) begin : g_bad_tick_div
        $error("adsr_envelope: TICK_DIV must be >= 2 and not exceed CLOCK_FREQUENCY");
    end

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t       state;
    env_state_t       state_next;
    logic [30:0]      amp_next;
    logic             done_next;
    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic             gate_d;
    logic             gate_rise;

    // Effective sustain and 32-bit intermediates: one spare bit means the
    // attack sum and the decay threshold can never wrap.
    logic [30:0] eff_sustain;
    logic [31:0] attack_sum;
    logic [31:0] decay_limit;
    logic [30:0] decay_diff;
    logic [30:0] release_diff;

    assign tick      = (tick_cnt == TICK_LAST);
    assign gate_rise = gate & ~gate_d;

    assign eff_sustain  = (sustain_level > peak_level) ? peak_level : sustain_level;
    assign attack_sum   = {1'b0, amplitude} + {16'd0, attack_step};
    assign decay_limit  = {1'b0, eff_sustain} + {16'd0, decay_step};
    // The differences are only selected when amplitude is strictly above
    // the floor, so 31 bits are enough and they never underflow.
    assign decay_diff   = amplitude - {15'd0, decay_step};
    assign release_diff = amplitude - {15'd0, release_step};

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the values from before the edge; combinational logic below uses '='.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            amplitude <= '0;
            done      <= 1'b0;
            tick_cnt  <= '0;
            gate_d    <= 1'b0;
        end else begin
            state     <= state_next;
            amplitude <= amp_next;
            done      <= done_next;
            tick_cnt  <= tick ? '0 : tick_cnt + CNT_W'(1);
            gate_d    <= gate;
        end
    end

    // NOTE: every output of this block is assigned a default first, so no
    // path through the if/case leaves a value unassigned and no latch appears.
    always_comb begin
        state_next = state;
        amp_next   = amplitude;
        done_next  = 1'b0;

        // Gate transitions win over the tick; amplitude holds that cycle.
        if (gate_rise && (state == ST_IDLE || state == ST_RELEASE)) begin
            state_next = ST_ATTACK;
        end else if (!gate && (state == ST_ATTACK || state == ST_DECAY ||
                               state == ST_SUSTAIN)) begin
            state_next = ST_RELEASE;
        end else if (tick) begin
            case (state)
                ST_ATTACK: begin
                    if (attack_step == 16'd0 || attack_sum >= {1'b0, peak_level}) begin
                        amp_next   = peak_level;
                        state_next = ST_DECAY;
                    end else begin
                        amp_next = attack_sum[30:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_step == 16'd0 || {1'b0, amplitude} <= decay_limit) begin
                        amp_next   = eff_sustain;
                        state_next = ST_SUSTAIN;
                    end else begin
                        amp_next = decay_diff;
                    end
                end
                ST_SUSTAIN: begin
                    // Re-sampled every tick so live sustain changes are followed.
                    amp_next = eff_sustain;
                end
                ST_RELEASE: begin
                    if (release_step == 16'd0 || amplitude <= {15'd0, release_step}) begin
                        amp_next   = '0;
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        amp_next = release_diff;
                    end
                end
                default: begin
                    amp_next = '0;
                end
            endcase
        end
    end

    assign env_state = state;
    assign active    = (state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// -----------------------------------------------------------------------------
// tb_adsr_envelope
//
// Self-checking bench for adsr_envelope with TICK_DIV=4. A cycle-level model
// built from the envelope rules (plain integer arithmetic, tick derived from
// the number of clocks since reset) is compared with the DUT after every
// clock; directed steps also compare against literal expected values.
// -----------------------------------------------------------------------------
module tb_adsr_envelope;

    localparam int TICK_DIV = 4;

    localparam int M_IDLE    = 0;
    localparam int M_ATTACK  = 1;
    localparam int M_DECAY   = 2;
    localparam int M_SUSTAIN = 3;
    localparam int M_RELEASE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [30:0] peak_level;
    logic [30:0] sustain_level;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] release_step;
    logic [30:0] amplitude;
    logic [2:0]  env_state;
    logic        active;
    logic        done;

    int errors = 0;
    int checks = 0;

    // Reference model state (values the DUT registers should hold).
    longint m_amp      = 0;
    int     m_state    = M_IDLE;
    bit     m_done     = 1'b0;
    bit     m_gate_old = 1'b0;
    int     m_phase    = 0;
    bit     m_ticked   = 1'b0;

    adsr_envelope #(
        .CLOCK_FREQUENCY(50000000),
        .TICK_DIV       (TICK_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .gate         (gate),
        .peak_level   (peak_level),
        .sustain_level(sustain_level),
        .attack_step  (attack_step),
        .decay_step   (decay_step),
        .release_step (release_step),
        .amplitude    (amplitude),
        .env_state    (env_state),
        .active       (active),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs as they stand now.
    task automatic model_step();
        longint peak;
        longint sus;
        longint nxt;
        bit     tick;
        m_done   = 1'b0;
        m_ticked = 1'b0;
        if (reset) begin
            m_amp      = 0;
            m_state    = M_IDLE;
            m_gate_old = 1'b0;
            m_phase    = 0;
        end else begin
            peak     = longint'(peak_level);
            sus      = (longint'(sustain_level) < peak) ? longint'(sustain_level) : peak;
            tick     = (m_phase == TICK_DIV - 1);
            m_ticked = tick;
            if (gate && !m_gate_old && (m_state == M_IDLE || m_state == M_RELEASE)) begin
                m_state = M_ATTACK;
            end else if (!gate && m_state inside {M_ATTACK, M_DECAY, M_SUSTAIN}) begin
                m_state = M_RELEASE;
            end else if (tick) begin
                if (m_state == M_ATTACK) begin
                    nxt = m_amp + longint'(attack_step);
                    if (attack_step == 0 || nxt >= peak) begin
                        m_amp   = peak;
                        m_state = M_DECAY;
                    end else m_amp = nxt;
                end else if (m_state == M_DECAY) begin
                    nxt = m_amp - longint'(decay_step);
                    if (decay_step == 0 || nxt <= sus) begin
                        m_amp   = sus;
                        m_state = M_SUSTAIN;
                    end else m_amp = nxt;
                end else if (m_state == M_SUSTAIN) begin
                    m_amp = sus;
                end else if (m_state == M_RELEASE) begin
                    nxt = m_amp - longint'(release_step);
                    if (release_step == 0 || nxt <= 0) begin
                        m_amp   = 0;
                        m_state = M_IDLE;
                        m_done  = 1'b1;
                    end else m_amp = nxt;
                end else begin
                    m_amp = 0;
                end
            end
            m_gate_old = gate;
            m_phase    = (m_phase + 1) % TICK_DIV;
        end
    endtask

    // One clock: model, edge, then compare all outputs 1 time unit later.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check("model_amp",    {1'b0, amplitude},   32'(m_amp));
        check("model_state",  {29'd0, env_state},  32'(m_state));
        check("model_active", {31'd0, active},     {31'd0, m_state != M_IDLE});
        check("model_done",   {31'd0, done},       {31'd0, m_done});
    endtask

    task automatic run_to_tick();
        bit hit = 1'b0;
        for (int i = 0; i < 2 * TICK_DIV; i++) begin
            cycle();
            if (m_ticked) begin
                hit = 1'b1;
                break;
            end
        end
        if (!hit) begin
            checks++;
            errors++;
            $error("FAIL tick_wait: observed=no_tick expected=tick within %0d cycles", 2 * TICK_DIV);
        end
    endtask

    task automatic expect_out(input string tag, input int amp, input int st);
        check({tag, "_amp"},   {1'b0, amplitude},  32'(amp));
        check({tag, "_state"}, {29'd0, env_state}, 32'(st));
    endtask

    task automatic default_settings();
        peak_level    = 31'd1000;
        sustain_level = 31'd400;
        attack_step   = 16'd300;
        decay_step    = 16'd250;
        release_step  = 16'd150;
    endtask

    task automatic random_settings();
        if ($urandom_range(0, 4) == 0)
            peak_level = 31'h7FFF_FFFF - 31'($urandom_range(0, 100));
        else
            peak_level = 31'($urandom_range(0, 3000));
        sustain_level = 31'($urandom_range(0, 3500));
        attack_step   = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
        decay_step    = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
        release_step  = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom_range(1, 700));
        if ($urandom_range(0, 9) == 0) attack_step = 16'hFFFF;
    endtask

    initial begin
        reset = 1'b1;
        gate  = 1'b1;
        default_settings();

        // Reset held with gate high.
        repeat (3) cycle();
        expect_out("reset", 0, M_IDLE);
        check("reset_active", {31'd0, active}, 32'd0);
        check("reset_done",   {31'd0, done},   32'd0);
        reset = 1'b0;
        cycle();
        expect_out("reset_release", 0, M_ATTACK);

        // Attack and decay into sustain.
        run_to_tick(); expect_out("att1", 300,  M_ATTACK);
        run_to_tick(); expect_out("att2", 600,  M_ATTACK);
        run_to_tick(); expect_out("att3", 900,  M_ATTACK);
        run_to_tick(); expect_out("att4", 1000, M_DECAY);
        run_to_tick(); expect_out("dec1", 750,  M_DECAY);
        run_to_tick(); expect_out("dec2", 500,  M_DECAY);
        run_to_tick(); expect_out("dec3", 400,  M_SUSTAIN);
        for (int i = 0; i < 5; i++) begin
            run_to_tick(); expect_out("sus_hold", 400, M_SUSTAIN);
        end
        sustain_level = 31'd350;
        run_to_tick(); expect_out("sus_live", 350, M_SUSTAIN);
        sustain_level = 31'd400;
        run_to_tick(); expect_out("sus_back", 400, M_SUSTAIN);

        // Release to idle.
        gate = 1'b0;
        cycle();       expect_out("rel_enter", 400, M_RELEASE);
        run_to_tick(); expect_out("rel1", 250, M_RELEASE);
        run_to_tick(); expect_out("rel2", 100, M_RELEASE);
        run_to_tick(); expect_out("rel3", 0,   M_IDLE);
        check("rel_done_pulse", {31'd0, done},   32'd1);
        check("rel_active_low", {31'd0, active}, 32'd0);
        cycle();
        check("rel_done_clear", {31'd0, done},   32'd0);

        // Retrigger from release.
        gate = 1'b1;
        cycle();
        for (int i = 0; i < 7; i++) run_to_tick();
        expect_out("rt_sustain", 400, M_SUSTAIN);
        gate = 1'b0;
        cycle();
        run_to_tick(); expect_out("rt_rel", 250, M_RELEASE);
        gate = 1'b1;
        cycle();       expect_out("rt_enter", 250, M_ATTACK);
        run_to_tick(); expect_out("rt1", 550,  M_ATTACK);
        run_to_tick(); expect_out("rt2", 850,  M_ATTACK);
        run_to_tick(); expect_out("rt3", 1000, M_DECAY);
        gate = 1'b0;
        cycle();       expect_out("rt_drop_dec", 1000, M_RELEASE);
        for (int i = 0; i < 5; i++) run_to_tick();
        expect_out("rt_rel250", 250, M_RELEASE);
        gate = 1'b1;
        cycle();
        run_to_tick(); expect_out("rt_att550", 550, M_ATTACK);
        gate = 1'b0;
        cycle();       expect_out("rt_drop_att", 550, M_RELEASE);
        run_to_tick(); expect_out("rt_rel400", 400, M_RELEASE);
        for (int i = 0; i < 3; i++) run_to_tick();
        expect_out("rt_idle", 0, M_IDLE);

        // Zero steps and sustain clamp.
        attack_step = 16'd0;
        gate = 1'b1;
        cycle();
        run_to_tick(); expect_out("zero_att", 1000, M_DECAY);
        decay_step = 16'd0;
        run_to_tick(); expect_out("zero_dec", 400, M_SUSTAIN);
        sustain_level = 31'd2000;
        run_to_tick(); expect_out("clamp_sus", 1000, M_SUSTAIN);
        release_step = 16'd0;
        gate = 1'b0;
        cycle();
        run_to_tick(); expect_out("zero_rel", 0, M_IDLE);
        check("zero_rel_done", {31'd0, done}, 32'd1);
        default_settings();

        // Reset mid-attack.
        gate = 1'b1;
        cycle();
        run_to_tick();
        run_to_tick(); expect_out("pre_reset", 600, M_ATTACK);
        reset = 1'b1;
        cycle();       expect_out("mid_reset", 0, M_IDLE);
        check("mid_reset_active", {31'd0, active}, 32'd0);
        reset = 1'b0;
        cycle();       expect_out("post_reset", 0, M_ATTACK);

        // Gate falls exactly in a tick cycle: release wins, amplitude holds.
        run_to_tick(); expect_out("prio_pre", 300, M_ATTACK);
        for (int i = 0; i < TICK_DIV && m_phase != TICK_DIV - 1; i++) cycle();
        gate = 1'b0;
        cycle();       expect_out("prio_tick", 300, M_RELEASE);
        check("prio_was_tick", {31'd0, m_ticked}, 32'd1);

        // Randomized run against the model.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) gate = ~gate;
            if ($urandom_range(0, 59) == 0) random_settings();
            reset = ($urandom_range(0, 249) == 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
